// File: rtl/m31_pkg.sv
// Shared Poseidon2-M31 types and constants.
// Used by the permutation sequencer and its neighbours.
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam int M31_WIDTH    = 16;
  localparam int M31_ROUNDS_F = 8;
  localparam int M31_ROUNDS_P = 14;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } perm_state_e;

endpackage

// File: rtl/m31_perm_ctrl.sv
// Poseidon2-M31 round sequencer over one shared round datapath.
// Define M31_PERM_CTRL_PERF_EN to add the completed-permutation counter.
module m31_perm_ctrl
  import m31_pkg::*;
#(
  parameter int WIDTH    = M31_WIDTH,
  parameter int ROUNDS_F = M31_ROUNDS_F,
  parameter int ROUNDS_P = M31_ROUNDS_P,
  parameter int RND_LAT  = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*31-1:0]  in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH*31-1:0]  out_state,
  output logic [WIDTH*31-1:0]  dp_state_o,
  output logic                 dp_issue_o,
  output logic                 dp_full_o,
  output logic [$clog2(ROUNDS_F+ROUNDS_P)-1:0] dp_rnd_o,
  input  logic [WIDTH*31-1:0]  dp_state_i,
  output logic                 busy_o
`ifdef M31_PERM_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cnt_o
`endif
);

  localparam int ROUNDS = ROUNDS_F + ROUNDS_P;
  localparam int RW     = $clog2(ROUNDS);
  localparam int LW     = $clog2(RND_LAT + 1);

  perm_state_e         st;
  logic [WIDTH*31-1:0] sreg;
  logic [RW-1:0]       rnd;
  logic [LW-1:0]       lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      sreg <= '0;
      rnd  <= '0;
      lat  <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            sreg <= in_state;
            rnd  <= '0;
            st   <= ISSUE;
          end
        end
        ISSUE: begin
          lat <= LW'(RND_LAT - 1);
          st  <= WAIT;
        end
        WAIT: begin
          if (lat == '0) begin
            sreg <= dp_state_i;
            if (rnd == RW'(ROUNDS - 1)) begin
              st <= DONE;
            end else begin
              rnd <= rnd + RW'(1);
              st  <= ISSUE;
            end
          end else begin
            lat <= lat - LW'(1);
          end
        end
        DONE: begin
          if (out_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Control outputs are decoded straight from the state register.
  assign in_ready   = rst_n && (st == IDLE);
  assign out_valid  = (st == DONE);
  assign busy_o     = (st != IDLE);
  assign dp_issue_o = (st == ISSUE);
  assign out_state  = sreg;
  assign dp_state_o = sreg;
  assign dp_rnd_o   = rnd;
  assign dp_full_o  = (rnd < RW'(ROUNDS_F / 2)) ||
                      (rnd >= RW'(ROUNDS_F / 2 + ROUNDS_P));

`ifdef M31_PERM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_o <= '0;
    end else if (out_valid && out_ready &&
                 (perf_cnt_o != 32'hFFFF_FFFF)) begin
      perf_cnt_o <= perf_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m31_perm_ctrl.sv
// Self-checking bench for m31_perm_ctrl with a delay-line datapath model.
// Checks perf_cnt_o too when M31_PERM_CTRL_PERF_EN is defined.
module tb_m31_perm_ctrl;

  localparam int W    = 16;
  localparam int RF   = 8;
  localparam int RP   = 14;
  localparam int LAT  = 13;
  localparam int R    = RF + RP;
  localparam int RW   = $clog2(R);
  localparam int SW   = W * 31;
  localparam int PERM = R * (LAT + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW-1:0] in_state = '0;
  logic          in_ready, out_valid, dp_issue_o, dp_full_o, busy_o;
  logic [SW-1:0] out_state, dp_state_o, dp_state_i;
  logic [RW-1:0] dp_rnd_o;
`ifdef M31_PERM_CTRL_PERF_EN
  logic [31:0]   perf_cnt_o;
`endif

  int  npass = 0;
  int  nfail = 0;
  int  ntot  = 0;
  bit  mix   = 1'b0;

  m31_perm_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .dp_state_o (dp_state_o),
    .dp_issue_o (dp_issue_o),
    .dp_full_o  (dp_full_o),
    .dp_rnd_o   (dp_rnd_o),
    .dp_state_i (dp_state_i),
    .busy_o     (busy_o)
`ifdef M31_PERM_CTRL_PERF_EN
    ,
    .perf_cnt_o (perf_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] dpf(input logic [SW-1:0] s,
                                        input int r);
    logic [SW-1:0] o;
    logic [30:0]   l;
    o = s;
    o[30:0] = o[30:0] + 31'(r + 1);
    if (mix) begin
      l = o[(r % W) * 31 +: 31];
      o[(r % W) * 31 +: 31] = l ^ 31'(r * 37 + 5);
    end
    return o;
  endfunction

  function automatic logic [SW-1:0] ref_perm(input logic [SW-1:0] s);
    logic [SW-1:0] o;
    o = s;
    for (int r = 0; r < R; r++) o = dpf(o, r);
    return o;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int i = 0; i < W; i++) s[i*31 +: 31] = 31'($urandom);
    return s;
  endfunction

  logic [SW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dpf(dp_state_o, int'(dp_rnd_o));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_state_i = pipe[LAT-1];

  task automatic chk(input string tag, input logic [SW-1:0] obs,
                     input logic [SW-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_perm(input logic [SW-1:0] st, input int bp,
                          input bit inject);
    logic [SW-1:0] expv, held;
    logic [R-1:0]  fulls, fexp;
    int cnt, nis;
    bit done, rnd_ok, gap_ok, stab;
    expv = ref_perm(st);
    fulls = '0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_state = rand_state();
    cnt = 0; nis = 0; done = 0; rnd_ok = 1; gap_ok = 1;
    while (cnt < PERM + 50) begin
      @(negedge clk);
      if (out_valid) begin
        done = 1;
        break;
      end
      if (dp_issue_o) begin
        if (int'(dp_rnd_o) != nis) rnd_ok = 0;
        if (cnt != nis * (LAT + 1)) gap_ok = 0;
        if (nis < R) fulls[nis] = dp_full_o;
        nis++;
      end
      if (inject && cnt == 100) begin
        chk("busy_in_ready", in_ready, 0);
        in_state = rand_state();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    for (int r = 0; r < R; r++)
      fexp[r] = (r < RF / 2) || (r >= RF / 2 + RP);
    chk("done_seen", done, 1);
    chk("latency", cnt, PERM);
    chk("issue_count", nis, R);
    chk("rnd_seq", rnd_ok, 1);
    chk("issue_gap", gap_ok, 1);
    chk("full_pattern", fulls, fexp);
    chk("out_state", out_state, expv);
    chk("no_ready_in_done", in_ready, 0);
    held = out_state;
    stab = 1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_state !== held || !out_valid || in_ready) stab = 0;
    end
    chk("bp_stable", stab, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy_o, 0);
  endtask

  initial begin
    logic [SW-1:0] s, e;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_issue", dp_issue_o, 0);
    chk("rst_full", dp_full_o, 1);
    chk("rst_rnd", dp_rnd_o, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_dp_state", dp_state_o, 0);
`ifdef M31_PERM_CTRL_PERF_EN
    chk("rst_perf", perf_cnt_o, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < W; i++) s[i*31 +: 31] = 31'(i);
    e = s;
    e[30:0] = 31'd253;
    chk("model_directed", ref_perm(s), e);
    run_perm(s, 50, 1'b0);
    chk("directed_lane0", out_state, e);

    mix = 1'b1;
    run_perm(rand_state(), 3, 1'b1);

    @(negedge clk);
    in_state = rand_state();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dp_issue_o && dp_rnd_o == RW'(10)) begin
        found = 1;
        break;
      end
    end
    chk("rnd10_seen", found, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_issue", dp_issue_o, 0);
    chk("arst_rnd", dp_rnd_o, 0);
    chk("arst_full", dp_full_o, 1);
    chk("arst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++)
      run_perm(rand_state(), int'($urandom_range(0, 5)), 1'b0);
`ifdef M31_PERM_CTRL_PERF_EN
    chk("perf_three", perf_cnt_o, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("perf_reset", perf_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
